// File: rtl/veririsc_pkg.sv
// Shared VeriRISC encodings: opcodes, instruction-cycle phases and the ALU-operand helper.
package veririsc_pkg;

    typedef enum logic [2:0] {
        OpHlt = 3'd0,
        OpSkz = 3'd1,
        OpAdd = 3'd2,
        OpAnd = 3'd3,
        OpXor = 3'd4,
        OpLda = 3'd5,
        OpSto = 3'd6,
        OpJmp = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        InstAddr  = 3'd0,
        InstFetch = 3'd1,
        InstLoad  = 3'd2,
        Idle      = 3'd3,
        OpAddr    = 3'd4,
        OpFetch   = 3'd5,
        AluOp     = 3'd6,
        Store     = 3'd7
    } phase_t;

    // Opcodes that read a memory operand into the accumulator.
    function automatic logic is_aluop(opcode_t op);
        return (op == OpAdd) || (op == OpAnd) || (op == OpXor) || (op == OpLda);
    endfunction

endpackage

// File: rtl/sequence_controller.sv
// VeriRISC control FSM: eight-phase instruction cycle with combinational strobe decode.
// Optional SEQ_SINGLE_STEP_EN adds step/waiting to hold at INST_ADDR until stepped.
module sequence_controller
    import veririsc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_,
    input  logic [2:0] opcode,
    input  logic       zero,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic       step,
    output logic       waiting,
`endif
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       load_ir,
    output logic       load_ac,
    output logic       load_pc,
    output logic       inc_pc,
    output logic       halt,
    output logic [2:0] phase
);

    phase_t  phase_q, phase_d;
    logic    halted_q, halted_d;
    logic    advance;
    opcode_t op;
    logic    aluop;

    assign op    = opcode_t'(opcode);
    assign aluop = is_aluop(op);
    assign phase = phase_q;

`ifdef SEQ_SINGLE_STEP_EN
    assign waiting = (phase_q == InstAddr);
`endif

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            phase_q  <= InstAddr;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        advance  = 1'b0;
        if (!halted_q) begin
            // A halt freezes the phase at OP_ADDR rather than advancing.
            if ((phase_q == OpAddr) && (op == OpHlt)) begin
                halted_d = 1'b1;
            end else begin
                advance = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
                if ((phase_q == InstAddr) && !step) begin
                    advance = 1'b0;
                end
`endif
            end
        end
        if (advance) begin
            phase_d = phase_t'(phase_q + 3'd1);
        end
    end

    always_comb begin
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        load_ir = 1'b0;
        load_ac = 1'b0;
        load_pc = 1'b0;
        inc_pc  = 1'b0;
        halt    = 1'b0;
        if (halted_q) begin
            halt = 1'b1;
        end else begin
            unique case (phase_q)
                InstAddr: ;
                InstFetch: mem_rd = 1'b1;
                InstLoad, Idle: begin
                    mem_rd  = 1'b1;
                    load_ir = 1'b1;
                end
                OpAddr: begin
                    if (op == OpHlt) halt   = 1'b1;
                    else             inc_pc = 1'b1;
                end
                OpFetch: mem_rd = aluop;
                AluOp: begin
                    mem_rd  = aluop;
                    load_ac = aluop;
                    inc_pc  = (op == OpSkz) && zero;
                    load_pc = (op == OpJmp);
                end
                Store: begin
                    mem_rd  = aluop;
                    load_ac = aluop;
                    load_pc = (op == OpJmp);
                    mem_wr  = (op == OpSto);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sequence_controller.sv
// Self-checking bench for sequence_controller: random programs against a phase/strobe model,
// plus directed halt and asynchronous-reset scenarios.
module tb_sequence_controller;

    logic       clk;
    logic       rst_;
    logic [2:0] opcode;
    logic       zero;
    logic       step;
    logic       waiting;
    logic       mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, halt;
    logic [2:0] phase;

    int n_assert = 0;
    int n_fail   = 0;

    int exp_phase  = 0;
    bit exp_halted = 0;

    sequence_controller dut (
        .clk     (clk),
        .rst_    (rst_),
        .opcode  (opcode),
        .zero    (zero),
`ifdef SEQ_SINGLE_STEP_EN
        .step    (step),
        .waiting (waiting),
`endif
        .mem_rd  (mem_rd),
        .mem_wr  (mem_wr),
        .load_ir (load_ir),
        .load_ac (load_ac),
        .load_pc (load_pc),
        .inc_pc  (inc_pc),
        .halt    (halt),
        .phase   (phase)
    );

`ifndef SEQ_SINGLE_STEP_EN
    assign waiting = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, halt} from the phase table.
    function automatic logic [6:0] exp_strobes(int ph, int op, bit z, bit halted);
        bit alu;
        logic [6:0] v;
        alu = (op == 2) || (op == 3) || (op == 4) || (op == 5);
        v = 7'b0;
        if (halted) return 7'b000_0001;
        case (ph)
            1: v[6] = 1'b1;
            2, 3: begin v[6] = 1'b1; v[4] = 1'b1; end
            4: if (op == 0) v[0] = 1'b1; else v[1] = 1'b1;
            5: v[6] = alu;
            6: begin v[6] = alu; v[3] = alu; v[1] = (op == 1) && z; v[2] = (op == 7); end
            7: begin v[6] = alu; v[3] = alu; v[2] = (op == 7); v[5] = (op == 6); end
            default: v = 7'b0;
        endcase
        return v;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic check_all(input string tag);
        logic [6:0] obs;
        obs = {mem_rd, mem_wr, load_ir, load_ac, load_pc, inc_pc, halt};
        chk({tag, "_phase"}, {5'b0, phase}, 8'(exp_phase));
        chk({tag, "_strobes"}, {1'b0, obs},
            {1'b0, exp_strobes(exp_phase, int'(opcode), zero, exp_halted)});
        chk({tag, "_pc_excl"}, {7'b0, load_pc & inc_pc}, 8'h00);
`ifdef SEQ_SINGLE_STEP_EN
        chk({tag, "_waiting"}, {7'b0, waiting}, {7'b0, exp_phase == 0});
`endif
    endtask

    // Called at a negedge; returns at the following negedge with the model advanced.
    task automatic run_cycles(input int n, input bit rand_op, input logic [2:0] fixed_op,
                              input string tag);
        for (int i = 0; i < n; i++) begin
            if (!rand_op) opcode = fixed_op;
            else if (exp_phase == 0) opcode = 3'($urandom_range(7, 1));
            zero = 1'($urandom);
`ifdef SEQ_SINGLE_STEP_EN
            step = ($urandom_range(3) == 0);
`endif
            #1;
            check_all(tag);
            @(posedge clk);
            if (!exp_halted) begin
                if (exp_phase == 4 && opcode == 3'd0) exp_halted = 1;
`ifdef SEQ_SINGLE_STEP_EN
                else if (exp_phase == 0 && !step) exp_phase = 0;
`endif
                else exp_phase = (exp_phase + 1) % 8;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int guard;
        rst_   = 1'b0;
        opcode = 3'd2;
        zero   = 1'b0;
        step   = 1'b0;
        #1;
        check_all("reset");
        @(negedge clk);
        rst_ = 1'b1;

        run_cycles(24, 1'b0, 3'd2, "add");
        run_cycles(400, 1'b1, 3'd0, "rand");

        // Halt: drive HLT from the start of an instruction and stay frozen at OP_ADDR.
        guard = 0;
        while (exp_phase != 0 && guard < 100) begin
            run_cycles(1, 1'b0, 3'd2, "align");
            guard++;
        end
        run_cycles(40, 1'b0, 3'd0, "hlt");
        chk("hlt_entered", {7'b0, halt}, 8'h01);

        rst_ = 1'b0;
        exp_phase  = 0;
        exp_halted = 0;
        #1;
        check_all("hlt_reset");
        @(negedge clk);
        rst_ = 1'b1;
        run_cycles(16, 1'b0, 3'd2, "post_hlt");

        // Asynchronous reset while an ADD is in ALU_OP.
        guard = 0;
        while (exp_phase != 6 && guard < 200) begin
            run_cycles(1, 1'b0, 3'd2, "to_alu");
            guard++;
        end
        chk("reached_alu_op", 8'(exp_phase), 8'd6);
        opcode = 3'd2;
        #1;
        chk("alu_load_ac", {7'b0, load_ac}, 8'h01);
        #2;
        rst_ = 1'b0;
        exp_phase  = 0;
        exp_halted = 0;
        #1;
        chk("async_load_ac", {7'b0, load_ac}, 8'h00);
        chk("async_mem_rd", {7'b0, mem_rd}, 8'h00);
        check_all("async_rst");
        @(negedge clk);
        rst_ = 1'b1;
        run_cycles(24, 1'b0, 3'd2, "restart");
        run_cycles(200, 1'b1, 3'd0, "rand2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sequence_controller.md
# sequence_controller

Central control FSM of the VeriRISC CPU. It steps through an eight-phase instruction cycle and decodes the current opcode into the strobes that drive the 5-bit program counter, instruction register, accumulator and memory. It sits between the instruction register, whose opcode field it reads, the ALU zero flag, and every load/increment/read/write enable in the datapath.

## Interface
Parameters:
- none; phase and opcode encodings are fixed in the package.

Ports:
- clk  in  1  system clock, rising edge.
- rst_  in  1  asynchronous, active-low reset.
- opcode  in  3  instruction opcode from the instruction register: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- zero  in  1  accumulator-is-zero flag from the ALU.
- mem_rd  out  1  memory read enable.
- mem_wr  out  1  memory write enable.
- load_ir  out  1  instruction register load.
- load_ac  out  1  accumulator load.
- load_pc  out  1  program counter parallel load (jump).
- inc_pc  out  1  program counter increment.
- halt  out  1  CPU halted, sticky.
- phase  out  3  current phase, for debug.

## Operation
- Phases cycle 0→7→0: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE.
- ALUOP is true for opcode ADD, AND, XOR or LDA.
- Strobes per phase; any strobe not listed is 0:
  - INST_ADDR: no strobes.
  - INST_FETCH: mem_rd.
  - INST_LOAD: mem_rd, load_ir.
  - IDLE: mem_rd, load_ir.
  - OP_ADDR: if opcode=HLT, halt; otherwise inc_pc.
  - OP_FETCH: mem_rd=ALUOP.
  - ALU_OP: mem_rd=ALUOP, load_ac=ALUOP, inc_pc=(SKZ and zero), load_pc=JMP.
  - STORE: mem_rd=ALUOP, load_ac=ALUOP, load_pc=JMP, mem_wr=STO.
- HLT: leaving OP_ADDR with opcode=HLT sets the halted flag.
  - While halted: phase stays at OP_ADDR (4), halt=1, all other strobes 0.
  - Only rst_ exits the halted state.
- load_pc and inc_pc are never both 1 in the same cycle. In ALU_OP, SKZ and JMP are mutually exclusive by opcode.
- opcode is driven from the instruction register and is stable from OP_ADDR through STORE. Its value in phases 0–3 is ignored.

## Timing
- Reset (async assert, sync release): phase=INST_ADDR, halted flag=0, all strobes 0, halt=0.
- Phase register advances on every rising clk unless halted (or stalled, see Configuration).
- Strobes are combinational from the registered phase, the halted flag, opcode and zero. No extra latency: a strobe is valid in the same cycle as its phase.
- One instruction takes exactly 8 cycles. The PC increments once in OP_ADDR, plus once more in ALU_OP for a taken SKZ.
- rst_ asserted mid-instruction: strobes drop to 0 immediately (asynchronously). The next instruction starts at INST_ADDR.
- Phase wraps 7→0 without a gap cycle.

## Configuration
- SEQ_SINGLE_STEP_EN defined:
  - Adds input step (1 bit) and output waiting (1 bit).
  - On reaching INST_ADDR, the FSM holds there with waiting=1 until a cycle where step=1. It advances to INST_FETCH on that edge.
  - step while not in INST_ADDR is ignored.
  - waiting resets to 1.
- SEQ_SINGLE_STEP_EN undefined: ports absent; free-running as described above.

## Structure
- Shared package veririsc_pkg holds:
  - opcode_t enum (3-bit, HLT..JMP).
  - phase_t enum (3-bit, INST_ADDR..STORE).
  - the is_aluop function.
- Single module, no sub-module: a phase register plus a combinational decode block. The datapath counter stays separate and is driven only through load_pc and inc_pc.

## Test plan
- Reset, then free-run with opcode=ADD → phase sequence 0..7 repeating. mem_rd high in phases 1,2,3,5,6,7. load_ac high in phases 6,7. inc_pc high in phase 4 only.
- opcode=SKZ, zero=1 → inc_pc high in phases 4 and 6. With zero=0 → inc_pc high in phase 4 only. load_ac stays 0 throughout.
- opcode=JMP → load_pc high in phases 6,7, inc_pc only in phase 4. opcode=STO → mem_wr high in phase 7 only, mem_rd 0 in phases 5–7.
- opcode=HLT at phase 4 → halt=1, inc_pc=0, phase frozen at 4 for 20+ cycles. Asserting rst_ → phase=0, halt=0.
- rst_ asserted asynchronously in phase 6 with opcode=ADD → load_ac and mem_rd fall before the next clk edge. After release, the sequence restarts at phase 0.
- SEQ_SINGLE_STEP_EN: phase holds at 0 with waiting=1. One step pulse → exactly one 8-cycle instruction, then hold at 0 again. step pulsed in phase 3 → no effect.
